// File: rtl/r_ram_to_uart_if.sv
// rtl/r_ram_to_uart_if.sv - RAM read port, control handshake and UART pin bundle for r_ram_to_uart
interface r_ram_to_uart_if;
   logic        r_ram_to_uart_start;
   logic [7:0]  dout;
   logic [14:0] address;
   logic        ena;
   logic        uart_txd;
   logic        busy;
   logic        r_ram_to_uart_end;

   // Transmitter side: reads the RAM, drives the serial line and status
   modport master (
      input  r_ram_to_uart_start,
      input  dout,
      output address,
      output ena,
      output uart_txd,
      output busy,
      output r_ram_to_uart_end
   );

   // Environment side: requests transfers and returns RAM data
   modport slave (
      output r_ram_to_uart_start,
      output dout,
      input  address,
      input  ena,
      input  uart_txd,
      input  busy,
      input  r_ram_to_uart_end
   );
endinterface

// File: rtl/r_ram_to_uart.sv
// rtl/r_ram_to_uart.sv - streams FULL_NUMBER RAM bytes out of an 8N1 UART transmitter
module r_ram_to_uart #(
   parameter int FULL_NUMBER = 6432,
   parameter int CLK_FREQ    = 50_000_000,
   parameter int BAUD        = 115200
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   r_ram_to_uart_if.master bus
);

   localparam int                BIT_CNT_MAX = CLK_FREQ / BAUD;
   localparam int                BAUD_W      = (BIT_CNT_MAX > 1) ? $clog2(BIT_CNT_MAX) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(BIT_CNT_MAX - 1);
   localparam logic [14:0]       LAST_ADDR   = 15'(FULL_NUMBER - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_ADDR = 3'd1;
   localparam logic [2:0] RD_WAIT = 3'd2;
   localparam logic [2:0] LOAD    = 3'd3;
   localparam logic [2:0] SEND    = 3'd4;
   localparam logic [2:0] NEXT    = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;

   logic [2:0]        r_state;
   logic [14:0]       r_counter;
   logic [7:0]        r_shift;
   logic [3:0]        r_bit_idx;
   logic [BAUD_W-1:0] r_baud;
   logic              r_txd;
   logic              r_end;

   logic              w_baud_wrap;
   logic              w_last_bit;
   logic              w_last_byte;

   // Bit 9 is the stop bit; wrapping out of it ends the frame
   assign w_baud_wrap = (r_baud == BAUD_LAST);
   assign w_last_bit  = (r_bit_idx == 4'd9);
   assign w_last_byte = (r_counter >= LAST_ADDR);

   // Sequencer: fetch a byte (two enabled read cycles), load, shift out, advance
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state   <= IDLE;
         r_counter <= '0;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_baud    <= '0;
         r_txd     <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_txd <= 1'b1;
               if (bus.r_ram_to_uart_start && !r_end) begin
                  r_state <= RD_ADDR;
               end
            end
            RD_ADDR: begin
               r_state <= RD_WAIT;
            end
            RD_WAIT: begin
               r_state <= LOAD;
            end
            LOAD: begin
               // Data is valid here thanks to the two-cycle RAM latency;
               // the line drops to the start bit on this same edge.
               r_shift   <= bus.dout;
               r_bit_idx <= '0;
               r_baud    <= '0;
               r_txd     <= 1'b0;
               r_state   <= SEND;
            end
            SEND: begin
               if (w_baud_wrap) begin
                  r_baud <= '0;
                  if (w_last_bit) begin
                     r_txd   <= 1'b1;
                     r_state <= NEXT;
                  end else begin
                     r_bit_idx <= r_bit_idx + 4'd1;
                     // Leaving bits 0..7 presents the next data bit LSB first;
                     // leaving bit 8 (d7) presents the stop bit.
                     if (r_bit_idx < 4'd8) begin
                        r_txd   <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                     end else begin
                        r_txd <= 1'b1;
                     end
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            NEXT: begin
               r_txd <= 1'b1;
               if (w_last_byte) begin
                  r_counter <= '0;
                  r_state   <= DONE;
               end else begin
                  r_counter <= r_counter + 15'd1;
                  r_state   <= RD_ADDR;
               end
            end
            DONE: begin
               r_txd   <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Completion flag: set on DONE entry (wins over a same-cycle start drop), cleared by start low
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_end <= 1'b0;
      end else if (r_state == NEXT && w_last_byte) begin
         r_end <= 1'b1;
      end else if (!bus.r_ram_to_uart_start) begin
         r_end <= 1'b0;
      end
   end

   assign bus.address           = r_counter;
   assign bus.ena               = (r_state == RD_ADDR) || (r_state == RD_WAIT);
   assign bus.busy              = (r_state != IDLE) && (r_state != DONE);
   assign bus.uart_txd          = r_txd;
   assign bus.r_ram_to_uart_end = r_end;

endmodule

// File: tb/tb_r_ram_to_uart.sv
// tb/tb_r_ram_to_uart.sv - directed self-checking bench for r_ram_to_uart (4 bytes, 4 clocks per bit)
module tb_r_ram_to_uart;

   localparam int FN   = 4;
   localparam int BITC = 4;
   localparam int PER  = 44;
   localparam int NCAP = 256;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b0;

   r_ram_to_uart_if bus ();

   r_ram_to_uart #(
      .FULL_NUMBER(FN),
      .CLK_FREQ   (4),
      .BAUD       (1)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .bus    (bus)
   );

   always #5 sys_clk = ~sys_clk;

   logic [7:0]  mem      [4];
   logic [7:0]  exp_data [4];
   logic [7:0]  ram_s1 = 8'h00;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   logic        cap_txd  [NCAP];
   logic        cap_ena  [NCAP];
   logic        cap_busy [NCAP];
   logic        cap_end  [NCAP];
   logic [14:0] cap_addr [NCAP];
   int          starts[$];

   // Two-cycle-latency RAM
   always @(posedge sys_clk) begin
      if (bus.ena) ram_s1 <= mem[bus.address[1:0]];
      bus.dout <= ram_s1;
   end

   task automatic capture(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk);
         cap_txd[base+i]  = bus.uart_txd;
         cap_ena[base+i]  = bus.ena;
         cap_busy[base+i] = bus.busy;
         cap_end[base+i]  = bus.r_ram_to_uart_end;
         cap_addr[base+i] = bus.address;
      end
   endtask

   task automatic do_reset();
      bus.r_ram_to_uart_start = 1'b0;
      @(negedge sys_clk);
      sys_rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
   endtask

   // Fill 'starts' with indices of start-bit falling edges in the capture
   task automatic scan_starts(input int n);
      starts.delete();
      for (int i = 1; i < n; i++) begin
         if (cap_txd[i-1] === 1'b1 && cap_txd[i] === 1'b0) begin
            starts.push_back(i);
            i += 40;
         end
      end
   endtask

   function automatic logic [7:0] decode_at(input int s);
      logic [7:0] v;
      for (int b = 0; b < 8; b++) v[b] = cap_txd[s + 2 + BITC * (b + 1)];
      return v;
   endfunction

   // Line levels over one 44-cycle byte slot: 3 idle, 10 bits x 4, 1 idle
   function automatic logic [PER-1:0] exp_wave(input logic [7:0] d);
      logic [PER-1:0] w;
      logic lvl;
      w = '1;
      for (int b = 0; b < 10; b++) begin
         if (b == 0) lvl = 1'b0;
         else if (b == 9) lvl = 1'b1;
         else lvl = d[b-1];
         for (int c = 0; c < BITC; c++) w[3 + b * BITC + c] = lvl;
      end
      return w;
   endfunction

   function automatic logic [PER-1:0] act_wave(input int base);
      logic [PER-1:0] w;
      for (int o = 0; o < PER; o++) w[o] = cap_txd[base + o];
      return w;
   endfunction

   task automatic test_reset();
      #2 sys_rst = 1'b1;
      #1;
      assert_cnt++; if (bus.uart_txd !== 1'b1) begin fail_cnt++; $display("FAIL rst_txd: got %b expected 1", bus.uart_txd); end
      assert_cnt++; if (bus.ena !== 1'b0) begin fail_cnt++; $display("FAIL rst_ena: got %b expected 0", bus.ena); end
      assert_cnt++; if (bus.busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
      assert_cnt++; if (bus.r_ram_to_uart_end !== 1'b0) begin fail_cnt++; $display("FAIL rst_end: got %b expected 0", bus.r_ram_to_uart_end); end
      assert_cnt++; if (bus.address !== 15'd0) begin fail_cnt++; $display("FAIL rst_addr: got %0d expected 0", bus.address); end
      bus.r_ram_to_uart_start = 1'b1;
      repeat (3) @(negedge sys_clk);
      assert_cnt++; if (bus.busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_hold_busy: got %b expected 0", bus.busy); end
      bus.r_ram_to_uart_start = 1'b0;
      sys_rst = 1'b0;
      @(negedge sys_clk);
   endtask

   task automatic test_full_transfer();
      do_reset();
      bus.r_ram_to_uart_start = 1'b1;
      capture(0, 190);
      for (int k = 0; k < FN; k++) begin
         assert_cnt++;
         if (act_wave(k * PER) !== exp_wave(exp_data[k])) begin
            fail_cnt++;
            $display("FAIL wave_byte%0d: got %h expected %h", k, act_wave(k * PER), exp_wave(exp_data[k]));
         end
      end
      scan_starts(190);
      assert_cnt++; if (starts.size() != FN) begin fail_cnt++; $display("FAIL frame_count: got %0d expected %0d", starts.size(), FN); end
      assert_cnt++; if (starts.size() > 0 && starts[0] != 3) begin fail_cnt++; $display("FAIL first_start: got %0d expected 3", starts[0]); end
      for (int k = 0; k < starts.size() && k < FN; k++) begin
         assert_cnt++;
         if (decode_at(starts[k]) !== exp_data[k]) begin fail_cnt++; $display("FAIL uart_byte%0d: got %h expected %h", k, decode_at(starts[k]), exp_data[k]); end
         assert_cnt++;
         if (cap_txd[starts[k] + 38] !== 1'b1) begin fail_cnt++; $display("FAIL stop_bit%0d: got %b expected 1", k, cap_txd[starts[k] + 38]); end
         if (k > 0) begin
            assert_cnt++;
            if (starts[k] - starts[k-1] != PER) begin fail_cnt++; $display("FAIL spacing%0d: got %0d expected %0d", k, starts[k] - starts[k-1], PER); end
         end
      end
      assert_cnt++; if (cap_end[175] !== 1'b0 || cap_busy[175] !== 1'b1) begin fail_cnt++; $display("FAIL next_status: got end=%b busy=%b expected end=0 busy=1", cap_end[175], cap_busy[175]); end
      assert_cnt++; if (cap_end[176] !== 1'b1 || cap_busy[176] !== 1'b0) begin fail_cnt++; $display("FAIL done_status: got end=%b busy=%b expected end=1 busy=0", cap_end[176], cap_busy[176]); end
      assert_cnt++; if (cap_end[177] !== 1'b1 || cap_busy[177] !== 1'b0) begin fail_cnt++; $display("FAIL end_held: got end=%b busy=%b expected end=1 busy=0", cap_end[177], cap_busy[177]); end
   endtask

   task automatic test_end_hold();
      int low_cnt, ena_cnt, busy_cnt, endlow_cnt;
      capture(0, 60);
      low_cnt = 0; ena_cnt = 0; busy_cnt = 0; endlow_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         if (cap_txd[i] !== 1'b1) low_cnt++;
         if (cap_ena[i] !== 1'b0) ena_cnt++;
         if (cap_busy[i] !== 1'b0) busy_cnt++;
         if (cap_end[i] !== 1'b1) endlow_cnt++;
      end
      assert_cnt++; if (low_cnt != 0) begin fail_cnt++; $display("FAIL hold_txd: got %0d non-idle cycles expected 0", low_cnt); end
      assert_cnt++; if (ena_cnt != 0) begin fail_cnt++; $display("FAIL hold_ena: got %0d enabled cycles expected 0", ena_cnt); end
      assert_cnt++; if (busy_cnt != 0) begin fail_cnt++; $display("FAIL hold_busy: got %0d busy cycles expected 0", busy_cnt); end
      assert_cnt++; if (endlow_cnt != 0) begin fail_cnt++; $display("FAIL hold_end: got %0d cycles with end low expected 0", endlow_cnt); end
      bus.r_ram_to_uart_start = 1'b0;
      @(negedge sys_clk);
      assert_cnt++; if (bus.r_ram_to_uart_end !== 1'b0) begin fail_cnt++; $display("FAIL end_clear: got %b expected 0", bus.r_ram_to_uart_end); end
      bus.r_ram_to_uart_start = 1'b1;
      capture(0, 45);
      assert_cnt++; if (cap_ena[0] !== 1'b1 || cap_addr[0] !== 15'd0) begin fail_cnt++; $display("FAIL restart_addr: got ena=%b addr=%0d expected ena=1 addr=0", cap_ena[0], cap_addr[0]); end
      assert_cnt++; if (act_wave(0) !== exp_wave(8'hA5)) begin fail_cnt++; $display("FAIL restart_wave: got %h expected %h", act_wave(0), exp_wave(8'hA5)); end
   endtask

   task automatic test_start_drop();
      int late_ena;
      do_reset();
      bus.r_ram_to_uart_start = 1'b1;
      capture(0, 50);
      bus.r_ram_to_uart_start = 1'b0;
      capture(50, 140);
      scan_starts(190);
      assert_cnt++; if (starts.size() != FN) begin fail_cnt++; $display("FAIL drop_frames: got %0d expected %0d", starts.size(), FN); end
      for (int k = 0; k < starts.size() && k < FN; k++) begin
         assert_cnt++;
         if (decode_at(starts[k]) !== exp_data[k]) begin fail_cnt++; $display("FAIL drop_byte%0d: got %h expected %h", k, decode_at(starts[k]), exp_data[k]); end
      end
      assert_cnt++; if (cap_end[175] !== 1'b0 || cap_end[176] !== 1'b1 || cap_end[177] !== 1'b0) begin
         fail_cnt++; $display("FAIL end_pulse: got %b%b%b expected 010", cap_end[175], cap_end[176], cap_end[177]);
      end
      late_ena = 0;
      for (int i = 177; i < 190; i++) if (cap_ena[i] !== 1'b0 || cap_busy[i] !== 1'b0) late_ena++;
      assert_cnt++; if (late_ena != 0) begin fail_cnt++; $display("FAIL drop_no_restart: got %0d active cycles expected 0", late_ena); end
   endtask

   task automatic test_addr_trace();
      logic [14:0] seen[$];
      do_reset();
      bus.r_ram_to_uart_start = 1'b1;
      capture(0, 190);
      bus.r_ram_to_uart_start = 1'b0;
      for (int i = 0; i < 190; i++) if (cap_ena[i] === 1'b1) seen.push_back(cap_addr[i]);
      assert_cnt++; if (seen.size() != 2 * FN) begin fail_cnt++; $display("FAIL ena_cycles: got %0d expected %0d", seen.size(), 2 * FN); end
      for (int j = 0; j < seen.size() && j < 2 * FN; j++) begin
         assert_cnt++;
         if (seen[j] !== 15'(j / 2)) begin fail_cnt++; $display("FAIL addr_seq%0d: got %0d expected %0d", j, seen[j], j / 2); end
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      bus.r_ram_to_uart_start = 1'b1;
      capture(0, 53);
      assert_cnt++; if (cap_txd[52] !== 1'b0 || cap_busy[52] !== 1'b1 || cap_addr[52] !== 15'd1) begin
         fail_cnt++; $display("FAIL pre_abort: got txd=%b busy=%b addr=%0d expected txd=0 busy=1 addr=1", cap_txd[52], cap_busy[52], cap_addr[52]);
      end
      #2 sys_rst = 1'b1;
      #1;
      assert_cnt++; if (bus.uart_txd !== 1'b1) begin fail_cnt++; $display("FAIL abort_txd: got %b expected 1", bus.uart_txd); end
      assert_cnt++; if (bus.busy !== 1'b0 || bus.ena !== 1'b0) begin fail_cnt++; $display("FAIL abort_busy_ena: got busy=%b ena=%b expected 0 0", bus.busy, bus.ena); end
      assert_cnt++; if (bus.address !== 15'd0 || bus.r_ram_to_uart_end !== 1'b0) begin fail_cnt++; $display("FAIL abort_addr_end: got addr=%0d end=%b expected 0 0", bus.address, bus.r_ram_to_uart_end); end
      @(negedge sys_clk);
      sys_rst = 1'b0;
      capture(0, 45);
      assert_cnt++; if (cap_ena[0] !== 1'b1 || cap_addr[0] !== 15'd0) begin fail_cnt++; $display("FAIL post_rst_addr: got ena=%b addr=%0d expected ena=1 addr=0", cap_ena[0], cap_addr[0]); end
      assert_cnt++; if (act_wave(0) !== exp_wave(8'hA5)) begin fail_cnt++; $display("FAIL post_rst_wave: got %h expected %h", act_wave(0), exp_wave(8'hA5)); end
   endtask

   initial begin
      mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h00;
      exp_data[0] = 8'hA5; exp_data[1] = 8'h3C; exp_data[2] = 8'hFF; exp_data[3] = 8'h00;
      bus.r_ram_to_uart_start = 1'b0;
      test_reset();
      test_full_transfer();
      test_end_hold();
      test_start_drop();
      test_addr_trace();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/r_ram_to_uart.md
R_RAM_TO_UART -- requirements
Module: r_ram_to_uart

Interface
REQ-001 Parameter FULL_NUMBER, default 6432: number of RAM bytes sent per transfer, addresses 0..FULL_NUMBER-1.
REQ-002 Parameter CLK_FREQ, default 50_000_000: sys_clk frequency in Hz.
REQ-003 Parameter BAUD, default 115200: UART bit rate; BIT_CNT_MAX = CLK_FREQ/BAUD (integer division, 434 at defaults) clocks per bit.
REQ-004 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-005 sys_rst  in  1  asynchronous, active-high reset.
REQ-006 r_ram_to_uart_start  in  1  level request to send the buffer.
REQ-007 dout  in  8  RAM read data, valid 2 cycles after address is presented with ena=1.
REQ-008 address  out  15  RAM read address, driven directly from the byte counter.
REQ-009 ena  out  1  RAM read enable.
REQ-010 uart_txd  out  1  serial output, 8N1, LSB first, idle high.
REQ-011 busy  out  1  high in every state except IDLE and DONE.
REQ-012 r_ram_to_uart_end  out  1  buffer fully sent; held until start drops.

Function
REQ-013 FSM states SHALL be IDLE, RD_ADDR, RD_WAIT, LOAD, SEND, NEXT, DONE.
REQ-014 IDLE: if start==1 and end==0, go to RD_ADDR; otherwise stay, with uart_txd=1 and ena=0.
REQ-015 RD_ADDR and RD_WAIT: ena=1 with address=counter, one cycle each.
REQ-016 LOAD: ena=0; capture dout into the 8-bit shift register; clear the bit index and baud counter; go to SEND.
REQ-017 SEND frame, BIT_CNT_MAX cycles per bit:
- start bit 0;
- data bits d[0]..d[7];
- stop bit 1.
REQ-018 Baud counter counts 0..BIT_CNT_MAX-1; the bit index advances when it wraps; after the last stop-bit cycle, go to NEXT.
REQ-019 NEXT, counter==FULL_NUMBER-1: counter<=0 and go to DONE.
REQ-020 NEXT, counter below FULL_NUMBER-1: counter<=counter+1 and go to RD_ADDR.
REQ-021 Per-byte period SHALL be 10*BIT_CNT_MAX+4 cycles; uart_txd stays high in the 4 non-SEND cycles.
REQ-022 DONE: set r_ram_to_uart_end=1 and go to IDLE.
REQ-023 r_ram_to_uart_end clears on the first cycle start==0 is sampled, in any state.
REQ-024 While end==1 and start==1, no new transfer starts.
REQ-025 Start is sampled only in IDLE; deasserting start mid-transfer does not abort, and all FULL_NUMBER bytes are sent.
REQ-026 The counter is 15 bits and never exceeds FULL_NUMBER-1; no wrap beyond the buffer.
REQ-027 Simultaneous start fall and DONE entry: end goes to 1 on DONE entry, then clears on the next cycle.
REQ-028 uart_txd SHALL be a registered output with no glitches.

Reset
REQ-029 sys_rst=1 SHALL immediately force:
- state IDLE;
- counter 0, shift register 0, bit index 0, baud counter 0;
- address 0, ena 0, busy 0, r_ram_to_uart_end 0;
- uart_txd 1.
REQ-030 Reset asserted mid-frame aborts the frame; uart_txd returns high asynchronously.
REQ-031 After reset release, a new transfer restarts from address 0.

Verification (sim parameters: FULL_NUMBER=4, CLK_FREQ=4, BAUD=1, so BIT_CNT_MAX=4; RAM model with 2-cycle latency holding 0xA5,0x3C,0xFF,0x00)
REQ-032 Start held high: UART monitor decodes 0xA5,0x3C,0xFF,0x00 in order. Byte-to-byte spacing is 44 cycles. end rises 1 cycle after the last stop bit and busy falls.
REQ-033 Frame check on byte 0xA5: uart_txd levels 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles.
REQ-034 Start dropped after the first byte: all 4 bytes are still sent; end pulses for 1 cycle, then clears.
REQ-035 Start held high after end: no second transfer and uart_txd stays 1. Dropping start clears end; reasserting start resends from address 0.
REQ-036 Reset asserted during the data bits of byte 2: uart_txd=1 and all outputs at reset values immediately. A transfer after release starts at address 0.
REQ-037 Address and ena trace: ena is high for exactly 2 cycles per byte, with addresses 0,1,2,3 in sequence and no out-of-range address.
